// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the bit-serial shift unit.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package shift_unit_seq_pkg;

    localparam int XLEN_DEF = 32;

    // Operation encoding is {funct7_5, funct3_2}
    typedef logic [1:0] op_t;
    localparam op_t OP_SLL = 2'b00;
    localparam op_t OP_SRL = 2'b01;
    localparam op_t OP_SRA = 2'b11;
    localparam op_t OP_ILL = 2'b10;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/shift_unit_seq_step.sv
// One-bit shift of the working word for SLL/SRL/SRA.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module shift_unit_seq_step
    import shift_unit_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] data,
    input  op_t             op,
    input  logic            sign,
    output logic [XLEN-1:0] shifted
);

    // Select the fill bit and direction from the latched operation
    always_comb begin
        shifted = data;
        case (op)
            OP_SLL:  shifted = {data[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, data[XLEN-1:1]};
            OP_SRA:  shifted = {sign, data[XLEN-1:1]};
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Bit-serial SLL/SRL/SRA unit: one bit of shift per clock.
// Latency: result valid shamt+1 cycles after accept; shamt+2 cycles per request.
// Backpressure: holds result in DONE until out_ready; in_ready low while busy or flushing.
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] Src1,
    input  logic [SHW-1:0]  Src2,
    input  logic            funct3_2,
    input  logic            funct7_5,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            busy
);

    state_t          state;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] step_dat;
    logic [SHW-1:0]  cnt;
    op_t             op;
    logic            sign;

    op_t  req_op;
    logic req_ill;

    assign req_op  = {funct7_5, funct3_2};
    assign req_ill = (req_op == OP_ILL);

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign Result    = data;

    shift_unit_seq_step #(
        .XLEN (XLEN)
    ) u_step (
        .data    (data),
        .op      (op),
        .sign    (sign),
        .shifted (step_dat)
    );

    // Controller: accept, shift one bit per cycle, hold result until consumed; flush wins
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            op    <= OP_SLL;
            sign  <= 1'b0;
        end else if (flush) begin
            // Working word is kept so Result stays quiet; it is simply not valid
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Illegal ops complete immediately with a zero result
                        data  <= req_ill ? '0 : Src1;
                        cnt   <= req_ill ? '0 : Src2;
                        op    <= req_op;
                        sign  <= Src1[XLEN-1] & funct7_5;
                        state <= (req_ill || (Src2 == '0)) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data <= step_dat;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus randomized traffic.
// Latency: n/a.
// Backpressure: randomized out_ready and flush.
module tb_shift_unit_seq;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Src1;
    logic [4:0]  Src2;
    logic        funct3_2;
    logic        funct7_5;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        busy;

    always #5 CLK = ~CLK;

    shift_unit_seq dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Src1      (Src1),
        .Src2      (Src2),
        .funct3_2  (funct3_2),
        .funct7_5  (funct7_5),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a request in flight is described by its operand, op,
    // shift amount, accept cycle and the cycle its result becomes valid.
    bit          m_act;
    int          m_n;
    int          m_rdy;
    logic [1:0]  m_op;
    logic [31:0] m_a;
    int          m_s;
    logic [31:0] m_vis;

    function automatic logic [31:0] shift_by(input logic [1:0] op, input logic [31:0] a, input int k);
        case (op)
            2'b00:   return a << k;
            2'b01:   return a >> k;
            2'b11:   return $signed(a) >>> k;
            default: return 32'h0;
        endcase
    endfunction

    // Value of the working word in the current cycle: k bits shifted so far
    function automatic logic [31:0] m_word();
        int k;
        k = cyc - m_n - 1;
        if (k > m_s) k = m_s;
        return shift_by(m_op, m_a, k);
    endfunction

    function automatic logic m_valid();
        return m_act && (cyc >= m_rdy);
    endfunction

    function automatic logic [31:0] m_result();
        return m_act ? m_word() : m_vis;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid()});
        chk("busy", {31'b0, busy}, {31'b0, m_act});
        chk("Result", Result, m_result());
        chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_act && !flush)});
    endtask

    // Advance the model across the coming clock edge using the applied inputs
    task automatic model_step();
        if (flush) begin
            if (m_act) m_vis = m_word();
            m_act = 0;
        end else if (m_act) begin
            if (cyc >= m_rdy && out_ready) begin
                m_vis = m_word();
                m_act = 0;
            end
        end else if (in_valid) begin
            m_act = 1;
            m_n   = cyc;
            m_op  = {funct7_5, funct3_2};
            m_a   = Src1;
            m_s   = (m_op == 2'b10) ? 0 : int'(Src2);
            m_rdy = cyc + 1 + m_s;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        check_all();
    endtask

    task automatic send(input logic f3, input logic f7, input logic [31:0] a,
                        input logic [4:0] s, output int n);
        int i;
        in_valid  = 0;
        out_ready = 1;
        flush     = 0;
        i = 0;
        while (m_act && i < 60) begin
            tick();
            i++;
        end
        if (m_act) chk("idle_timeout", 32'd1, 32'd0);
        in_valid = 1;
        funct3_2 = f3;
        funct7_5 = f7;
        Src1     = a;
        Src2     = s;
        n        = cyc;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_valid(input int n, output int lat);
        int i;
        i = 0;
        while (!out_valid && i < 40) begin
            tick();
            i++;
        end
        if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
        lat = cyc - n;
    endtask

    task automatic directed(input string name, input logic f3, input logic f7,
                            input logic [31:0] a, input logic [4:0] s,
                            input logic [31:0] exp_res, input int exp_lat);
        int n;
        int lat;
        send(f3, f7, a, s, n);
        out_ready = 1;
        wait_valid(n, lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_res"}, Result, exp_res);
        tick();
    endtask

    initial begin
        int n;
        int lat;
        bit seen;

        rst_n = 0; in_valid = 0; Src1 = 0; Src2 = 0;
        funct3_2 = 0; funct7_5 = 0; flush = 0; out_ready = 0;
        m_act = 0; m_vis = 0; m_n = 0; m_rdy = 0; m_op = 0; m_a = 0; m_s = 0;
        repeat (2) @(negedge CLK);
        rst_n = 1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", Result, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        directed("sll31", 1'b0, 1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
        directed("sra4",  1'b1, 1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, 5);
        directed("srl4",  1'b1, 1'b0, 32'h8000_0000, 5'd4,  32'h0800_0000, 5);
        directed("sll0",  1'b0, 1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
        directed("srl0",  1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
        directed("sra0",  1'b1, 1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
        directed("ill",   1'b0, 1'b1, 32'hDEAD_BEEF, 5'd7,  32'h0000_0000, 1);
        directed("sra_pos", 1'b1, 1'b1, 32'h4000_0000, 5'd3, 32'h0800_0000, 4);

        // Consumer stalls for three cycles
        send(1'b1, 1'b0, 32'h0000_0080, 5'd3, n);
        out_ready = 0;
        wait_valid(n, lat);
        chk("hold_lat", lat, 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_result", Result, 32'h0000_0010);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1;
        tick();
        chk("post_hs_busy", {31'b0, busy}, 32'd0);
        chk("post_hs_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush during a 20-bit shift
        send(1'b0, 1'b0, 32'h0000_0001, 5'd20, n);
        tick();
        tick();
        chk("flush_at_n3", cyc, n + 3);
        flush = 1;
        tick();
        flush = 0;
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_result_held", Result, 32'h0000_0004);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk("flush_no_valid", {31'b0, seen}, 32'd0);
        directed("after_flush", 1'b1, 1'b1, 32'hF000_000F, 5'd8, 32'hFFF0_0000, 9);

        // Asynchronous reset in the middle of a shift
        send(1'b0, 1'b0, 32'h0000_0003, 5'd10, n);
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_result", Result, 32'h0);
        m_act = 0;
        m_vis = 0;
        @(negedge CLK);
        rst_n = 1;
        cyc++;
        #1;
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        directed("after_rst", 1'b1, 1'b0, 32'h0000_00F0, 5'd4, 32'h0000_000F, 5);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            funct3_2  = 1'($urandom_range(0, 1));
            funct7_5  = 1'($urandom_range(0, 1));
            Src1      = $urandom;
            Src2      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid = 0;
        flush    = 0;
        out_ready = 1;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
